// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the sram_array bank.
//   - sram_state_e : controller FSM states (INIT, IDLE, RD, RESP)
//   - parity()     : even parity of a word (XOR of all bits)
//   - byte_merge() : per-byte merge of a new word into an old word
// The helpers operate on a MAX_W-bit container so that any DATA_W up to
// MAX_W can use them.  Callers zero-extend their operands, which changes
// neither the parity nor the merged low bits, and then truncate the result.
// Optional feature macro used by the bank: SRAM_PARITY_EN.
package sram_pkg;

  localparam int MAX_W    = 256;
  localparam int MAX_BE_W = MAX_W / 8;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } sram_state_e;

  function automatic logic parity(input logic [MAX_W-1:0] w);
    return ^w;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]    old_w,
                                                   input logic [MAX_W-1:0]    new_w,
                                                   input logic [MAX_BE_W-1:0] be);
    logic [MAX_W-1:0] out_w;
    out_w = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) out_w[8*i +: 8] = new_w[8*i +: 8];
    end
    return out_w;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// sram_bank: DEPTH x DATA_W storage with one byte-enabled write port and
// one registered read port.
// Ports:
//   clk      clock
//   i_we     write strobe; the addressed word is merged with i_wdata/i_be
//   i_waddr  write word address
//   i_wdata  write data
//   i_be     byte enables, bit i covers i_wdata[8i+7:8i]
//   i_inj    store inverted parity for this write (parity build only)
//   i_re     read strobe; o_rdata/o_rpar load on the next edge
//   i_raddr  read word address
//   o_rdata  registered read data
//   o_rpar   registered stored parity bit (0 when parity is not built)
// Macro SRAM_PARITY_EN adds a one-bit parity column.  Parity is taken over
// the merged post-write word, so partial writes keep it consistent.
module sram_bank
  import sram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 6,
  localparam int BE_W   = DATA_W / 8,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_inj,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rpar
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;

  // Read-modify-write: unselected bytes come from the current word.
  assign w_merged = DATA_W'(byte_merge(MAX_W'(r_mem[i_waddr]),
                                       MAX_W'(i_wdata),
                                       MAX_BE_W'(i_be)));

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= w_merged;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

`ifdef SRAM_PARITY_EN
  logic r_par_mem [DEPTH];
  logic r_rpar;

  always_ff @(posedge clk) begin
    if (i_we) r_par_mem[i_waddr] <= parity(MAX_W'(w_merged)) ^ i_inj;
    if (i_re) r_rpar <= r_par_mem[i_raddr];
  end

  assign o_rpar = r_rpar;
`else
  logic w_unused_inj;
  assign w_unused_inj = i_inj;
  assign o_rpar       = 1'b0;
`endif

endmodule

// File: rtl/sram_array.sv
// sram_array: word-addressed SRAM bank with byte enables, registered read
// path, valid/ready request/response handshake and a post-reset clear sweep.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake; req_ready = (state == IDLE)
//   req_we            1 = write, 0 = read
//   req_addr          word address
//   req_wdata/req_be  write data and byte enables
//   inj_err           on an accepted write, store inverted parity
//   rsp_valid/ready   read response handshake
//   rsp_rdata/rsp_err read data and parity error flag
//   init_done         clear sweep complete
//   dbg_state         current controller state
// Macro SRAM_PARITY_EN enables parity storage/checking; otherwise rsp_err
// is 0 and inj_err has no effect.
//
// Handshake: a request transfers on an edge where req_valid & req_ready;
// a response transfers on an edge where rsp_valid & rsp_ready, and
// rsp_rdata/rsp_err are held until then.  rsp_ready with rsp_valid low is
// ignored.
module sram_array
  import sram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 6,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              inj_err,
  output logic              init_done,
  output sram_state_e       dbg_state
);

  sram_state_e       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_init_done;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_inj;
  logic              w_re;
  logic [DATA_W-1:0] w_bank_rdata;
  logic              w_bank_rpar;
  logic              w_err;

  // The sweep owns the write port in INIT; requests own it in IDLE.
  // Reset blocks a write that happens to coincide with it.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = req_addr;
    w_wdata = req_wdata;
    w_be    = req_be;
    w_inj   = 1'b0;
    if (r_state == INIT) begin
      w_we    = ~rst;
      w_waddr = r_cnt;
      w_wdata = '0;
      w_be    = '1;
    end else if (r_state == IDLE) begin
      w_we  = ~rst & req_valid & req_we;
      w_inj = inj_err;
    end
  end

  assign w_re = (r_state == RD);

  sram_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_be   (w_be),
    .i_inj  (w_inj),
    .i_re   (w_re),
    .i_raddr(r_raddr),
    .o_rdata(w_bank_rdata),
    .o_rpar (w_bank_rpar)
  );

`ifdef SRAM_PARITY_EN
  assign w_err = (parity(MAX_W'(w_bank_rdata)) != w_bank_rpar);
`else
  logic w_unused_rpar;
  assign w_unused_rpar = w_bank_rpar;
  assign w_err         = 1'b0;
`endif

  // RD issues the bank read; the first RESP cycle captures the bank output
  // into the response registers, after which rsp_valid is held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_raddr     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (&r_cnt) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && !req_we) begin
            r_raddr <= req_addr;
            r_state <= RD;
          end
        end
        RD: begin
          r_state <= RESP;
        end
        RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_bank_rdata;
            r_rsp_err   <= w_err;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign init_done = r_init_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array: randomized bench for sram_array (DATA_W=32, ADDR_W=4).
// A memory model (plain arrays) predicts each read; expected responses go
// into exp_q when a read is accepted and a monitor pops and compares them
// whenever a response transfers.  Directed sections cover reset/init
// timing, partial writes, backpressure, back-to-back writes, reset during
// RESP and parity injection (parity results follow SRAM_PARITY_EN).
module tb_sram_array;
  import sram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be    = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          inj_err   = 1'b0;
  logic          init_done;
  sram_state_e   dbg_state;

  sram_array #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .inj_err  (inj_err),
    .init_done(init_done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0]   exp_q[$];      // {err, data}
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_par [DEPTH];
  logic [DW:0]   mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_par[i] = 1'b0;
    end
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [BW-1:0] be, input logic inj);
    for (int i = 0; i < BW; i++)
      if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    m_par[a] = (^m_mem[a]) ^ inj;
  endfunction

  function automatic logic [DW:0] model_read(input logic [AW-1:0] a);
    logic err;
`ifdef SRAM_PARITY_EN
    err = ((^m_mem[a]) != m_par[a]);
`else
    err = 1'b0;
`endif
    return {err, m_mem[a]};
  endfunction

  // Monitor: compare every response that transfers.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got %0h expected no response", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {31'b0, rsp_err, rsp_rdata}, {31'b0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Tasks start just after a rising edge and return just after one.
  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err,   0);
    @(posedge clk);
    #1 rst = 1'b0;
    // Negedge k=0 precedes E0; init_done must rise only after E(DEPTH-1).
    for (int k = 0; k <= DEPTH; k++) begin
      @(negedge clk);
      check("init_done_t", init_done, (k == DEPTH) ? 1 : 0);
      check("init_ready_t", req_ready, (k == DEPTH) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be, input logic inj, input bit chk_ready);
    int guard;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    inj_err   = inj;
    @(negedge clk);
    if (chk_ready) check("b2b_ready", req_ready, 1);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) fail_now("write_accept");
    @(posedge clk);
    if (req_ready) model_write(a, d, be, inj);
    #1;
    req_valid = 1'b0;
    inj_err   = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int guard;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) fail_now("read_accept");
    @(posedge clk);
    exp_q.push_back(model_read(a));
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("lat_n0", rsp_valid, 0);
    @(negedge clk);
    check("lat_n1", rsp_valid, 0);
    @(negedge clk);
    check("lat_n2", rsp_valid, 1);
    if (rsp_ready) begin
      @(negedge clk);
      check("lat_drop", rsp_valid, 0);
      check("ready_back", req_ready, 1);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW:0] e5;
    int guard;

    apply_reset(3);

    // Cleared words
    do_read(AW'(0));
    do_read(AW'(DEPTH - 1));

    // Full then partial write
    do_write(AW'(3), 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    do_write(AW'(3), 32'h00001122, 4'b0011, 1'b0, 1'b0);
    do_read(AW'(3));
    check("partial_model", m_mem[3], 32'hDEAD1122);

    // be = 0 leaves word unchanged
    do_write(AW'(3), 32'h55555555, 4'h0, 1'b0, 1'b0);
    do_read(AW'(3));

    // Backpressure on addr 5
    do_write(AW'(5), 32'hA5A5_0F0F, 4'hF, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    do_read(AW'(5));
    e5 = model_read(AW'(5));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data",  rsp_rdata, e5[DW-1:0]);
      check("hold_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_back", req_ready, 1);
    check("bp_valid_low",  rsp_valid, 0);
    @(posedge clk);
    #1;

    // Back-to-back writes to 0..7, then readback
    for (int i = 0; i < 8; i++)
      do_write(AW'(i), $urandom, 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      do_read(AW'(i));

    // Parity injection (expected error only when parity is built)
    do_write(AW'(1), 32'h1, 4'hF, 1'b1, 1'b0);
    do_read(AW'(1));
    do_write(AW'(1), 32'h1, 4'hF, 1'b0, 1'b0);
    do_read(AW'(1));

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      logic [BW-1:0] be;
      logic          inj;
      a   = AW'($urandom_range(0, DEPTH - 1));
      be  = BW'($urandom_range(0, 15));
      inj = (be != 0) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, be, inj, 1'b0);
      else                           do_read(a);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset while a response is pending
    do_write(AW'(2), 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    do_read(AW'(2));
    check("pre_rst_valid", rsp_valid, 1);
    apply_reset(1);
    rsp_ready = 1'b1;
    do_read(AW'(2));
    do_read(AW'(0));

    // Drain scoreboard
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) fail_now("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
